// File: rtl/id_fwd_stage.sv
// Registered MIPS decode stage: owns the ID/EX register, resolves operands from
// multiple forwarding sources and stalls while a matching source is not ready.
module id_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned AOP_W  = 8,
  parameter int unsigned ASEL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     flush_i,
  output logic                     reg1_read_o,
  output logic                     reg2_read_o,
  output logic [4:0]               reg1_addr_o,
  output logic [4:0]               reg2_addr_o,
  input  logic [DATA_W-1:0]        reg1_data_i,
  input  logic [DATA_W-1:0]        reg2_data_i,
  input  logic [NFWD-1:0]          fwd_wreg_i,
  input  logic [5*NFWD-1:0]        fwd_wd_i,
  input  logic [DATA_W*NFWD-1:0]   fwd_wdata_i,
  input  logic [NFWD-1:0]          fwd_rdy_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AOP_W-1:0]         aluop_o,
  output logic [ASEL_W-1:0]        alusel_o,
  output logic [DATA_W-1:0]        reg1_o,
  output logic [DATA_W-1:0]        reg2_o,
  output logic [4:0]               wd_o,
  output logic                     wreg_o,
  output logic [DATA_W-1:0]        pc_o,
  output logic                     inst_invalid_o
);

  // Opcode and SPECIAL function fields
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_SYNC = 6'h0F;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  // Shared ALU op / result-select encodings
  localparam logic [AOP_W-1:0] ALU_NOP  = AOP_W'(8'h00);
  localparam logic [AOP_W-1:0] ALU_AND  = AOP_W'(8'h24);
  localparam logic [AOP_W-1:0] ALU_OR   = AOP_W'(8'h25);
  localparam logic [AOP_W-1:0] ALU_XOR  = AOP_W'(8'h26);
  localparam logic [AOP_W-1:0] ALU_NOR  = AOP_W'(8'h27);
  localparam logic [AOP_W-1:0] ALU_SLL  = AOP_W'(8'h7C);
  localparam logic [AOP_W-1:0] ALU_SRL  = AOP_W'(8'h02);
  localparam logic [AOP_W-1:0] ALU_SRA  = AOP_W'(8'h03);
  localparam logic [AOP_W-1:0] ALU_MOVZ = AOP_W'(8'h0A);
  localparam logic [AOP_W-1:0] ALU_MOVN = AOP_W'(8'h0B);
  localparam logic [AOP_W-1:0] ALU_MFHI = AOP_W'(8'h10);
  localparam logic [AOP_W-1:0] ALU_MTHI = AOP_W'(8'h11);
  localparam logic [AOP_W-1:0] ALU_MFLO = AOP_W'(8'h12);
  localparam logic [AOP_W-1:0] ALU_MTLO = AOP_W'(8'h13);

  localparam logic [ASEL_W-1:0] SEL_NOP   = ASEL_W'(3'd0);
  localparam logic [ASEL_W-1:0] SEL_LOGIC = ASEL_W'(3'd1);
  localparam logic [ASEL_W-1:0] SEL_SHIFT = ASEL_W'(3'd2);
  localparam logic [ASEL_W-1:0] SEL_MOVE  = ASEL_W'(3'd3);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm16;

  assign w_op    = inst_i[31:26];
  assign w_rs    = inst_i[25:21];
  assign w_rt    = inst_i[20:16];
  assign w_rd    = inst_i[15:11];
  assign w_shamt = inst_i[10:6];
  assign w_funct = inst_i[5:0];
  assign w_imm16 = inst_i[15:0];

  logic              w_dec_ok;
  logic              w_rd1_en;
  logic              w_rd2_en;
  logic              w_we_dec;
  logic              w_use_imm1;
  logic              w_use_imm2;
  logic              w_is_lui;
  logic              w_is_movn;
  logic              w_is_movz;
  logic [AOP_W-1:0]  w_aluop;
  logic [ASEL_W-1:0] w_alusel;
  logic [4:0]        w_dest;

  // Instruction decode; anything not matched stays an invalid NOP
  always_comb begin
    w_dec_ok   = 1'b0;
    w_rd1_en   = 1'b0;
    w_rd2_en   = 1'b0;
    w_we_dec   = 1'b0;
    w_use_imm1 = 1'b0;
    w_use_imm2 = 1'b0;
    w_is_lui   = 1'b0;
    w_is_movn  = 1'b0;
    w_is_movz  = 1'b0;
    w_aluop    = ALU_NOP;
    w_alusel   = SEL_NOP;
    w_dest     = w_rd;

    if (w_op == OP_SPECIAL && w_shamt == 5'd0) begin
      case (w_funct)
        FN_AND, FN_OR, FN_XOR, FN_NOR: begin
          w_dec_ok = 1'b1;
          w_rd1_en = 1'b1;
          w_rd2_en = 1'b1;
          w_we_dec = 1'b1;
          w_alusel = SEL_LOGIC;
          case (w_funct)
            FN_AND:  w_aluop = ALU_AND;
            FN_OR:   w_aluop = ALU_OR;
            FN_XOR:  w_aluop = ALU_XOR;
            default: w_aluop = ALU_NOR;
          endcase
        end
        FN_SLLV, FN_SRLV, FN_SRAV: begin
          w_dec_ok = 1'b1;
          w_rd1_en = 1'b1;
          w_rd2_en = 1'b1;
          w_we_dec = 1'b1;
          w_alusel = SEL_SHIFT;
          case (w_funct)
            FN_SLLV: w_aluop = ALU_SLL;
            FN_SRLV: w_aluop = ALU_SRL;
            default: w_aluop = ALU_SRA;
          endcase
        end
        FN_MFHI, FN_MFLO: begin
          w_dec_ok = 1'b1;
          w_we_dec = 1'b1;
          w_alusel = SEL_MOVE;
          w_aluop  = (w_funct == FN_MFHI) ? ALU_MFHI : ALU_MFLO;
        end
        FN_MTHI, FN_MTLO: begin
          w_dec_ok = 1'b1;
          w_rd1_en = 1'b1;
          w_aluop  = (w_funct == FN_MTHI) ? ALU_MTHI : ALU_MTLO;
        end
        FN_MOVN, FN_MOVZ: begin
          w_dec_ok  = 1'b1;
          w_rd1_en  = 1'b1;
          w_rd2_en  = 1'b1;
          w_we_dec  = 1'b1;
          w_alusel  = SEL_MOVE;
          w_is_movn = (w_funct == FN_MOVN);
          w_is_movz = (w_funct == FN_MOVZ);
          w_aluop   = (w_funct == FN_MOVN) ? ALU_MOVN : ALU_MOVZ;
        end
        FN_SYNC: w_dec_ok = 1'b1;
        default: ;
      endcase
    end

    // Immediate shifts: shamt feeds port 1, rt is read on port 2
    if (w_op == OP_SPECIAL && w_rs == 5'd0) begin
      case (w_funct)
        FN_SLL, FN_SRL, FN_SRA: begin
          w_dec_ok   = 1'b1;
          w_rd2_en   = 1'b1;
          w_use_imm1 = 1'b1;
          w_we_dec   = 1'b1;
          w_alusel   = SEL_SHIFT;
          case (w_funct)
            FN_SLL:  w_aluop = ALU_SLL;
            FN_SRL:  w_aluop = ALU_SRL;
            default: w_aluop = ALU_SRA;
          endcase
        end
        default: ;
      endcase
    end

    case (w_op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        w_dec_ok   = 1'b1;
        w_rd1_en   = (w_op != OP_LUI);
        w_use_imm2 = 1'b1;
        w_is_lui   = (w_op == OP_LUI);
        w_we_dec   = 1'b1;
        w_dest     = w_rt;
        w_alusel   = SEL_LOGIC;
        case (w_op)
          OP_ANDI: w_aluop = ALU_AND;
          OP_XORI: w_aluop = ALU_XOR;
          default: w_aluop = ALU_OR;
        endcase
      end
      OP_PREF: w_dec_ok = 1'b1;
      default: ;
    endcase
  end

  assign reg1_read_o = w_rd1_en;
  assign reg2_read_o = w_rd2_en;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  logic [DATA_W-1:0] w_imm1;
  logic [DATA_W-1:0] w_imm2;
  assign w_imm1 = DATA_W'(w_shamt);
  assign w_imm2 = w_is_lui ? DATA_W'({w_imm16, 16'h0000}) : DATA_W'(w_imm16);

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_haz1;
  logic              w_haz2;

  // Operand resolution; scanning oldest to youngest lets the lowest index win
  always_comb begin
    w_op1  = '0;
    w_haz1 = 1'b0;
    if (!w_rd1_en) begin
      w_op1 = w_use_imm1 ? w_imm1 : '0;
    end else if (w_rs != 5'd0) begin
      w_op1 = reg1_data_i;
      for (int k = int'(NFWD) - 1; k >= 0; k--) begin
        if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == w_rs) begin
          w_op1  = fwd_wdata_i[DATA_W*k +: DATA_W];
          w_haz1 = !fwd_rdy_i[k];
        end
      end
    end
  end

  always_comb begin
    w_op2  = '0;
    w_haz2 = 1'b0;
    if (!w_rd2_en) begin
      w_op2 = w_use_imm2 ? w_imm2 : '0;
    end else if (w_rt != 5'd0) begin
      w_op2 = reg2_data_i;
      for (int k = int'(NFWD) - 1; k >= 0; k--) begin
        if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == w_rt) begin
          w_op2  = fwd_wdata_i[DATA_W*k +: DATA_W];
          w_haz2 = !fwd_rdy_i[k];
        end
      end
    end
  end

  logic       w_hazard;
  logic       w_accept;
  logic       w_wreg;
  logic [4:0] w_wd;

  assign w_hazard = w_haz1 || w_haz2;
  assign in_ready = rst && !flush_i && !w_hazard && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Register $0 is never a real destination; movn/movz gate on resolved rt
  assign w_wd   = w_we_dec ? w_dest : 5'd0;
  assign w_wreg = w_we_dec && (w_wd != 5'd0)
               && (!w_is_movn || (w_op2 != '0))
               && (!w_is_movz || (w_op2 == '0));

  logic              r_valid;
  logic [AOP_W-1:0]  r_aluop;
  logic [ASEL_W-1:0] r_alusel;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [4:0]        r_wd;
  logic              r_wreg;
  logic [DATA_W-1:0] r_pc;
  logic              r_invalid;

  // ID/EX register: flush beats capture, capture beats drain
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_aluop   <= ALU_NOP;
      r_alusel  <= SEL_NOP;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wd      <= 5'd0;
      r_wreg    <= 1'b0;
      r_pc      <= '0;
      r_invalid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= w_op1;
      r_reg2    <= w_op2;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_pc      <= pc_i;
      r_invalid <= !w_dec_ok;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_invalid;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: directed cases plus randomized traffic checked
// against an instruction-level reference model.
module tb_id_fwd_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = 3;

  localparam logic [7:0] A_NOP  = 8'h00, A_AND  = 8'h24, A_OR   = 8'h25, A_XOR  = 8'h26;
  localparam logic [7:0] A_NOR  = 8'h27, A_SLL  = 8'h7C, A_SRL  = 8'h02, A_SRA  = 8'h03;
  localparam logic [7:0] A_MOVZ = 8'h0A, A_MOVN = 8'h0B, A_MFHI = 8'h10, A_MTHI = 8'h11;
  localparam logic [7:0] A_MFLO = 8'h12, A_MTLO = 8'h13;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_MOVE = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0]   pc, rd1, rd2;
  logic [31:0]     inst;
  logic            r1_en, r2_en;
  logic [4:0]      r1_addr, r2_addr;
  logic [NF-1:0]   fwd_wreg, fwd_rdy;
  logic [5*NF-1:0] fwd_wd;
  logic [DW*NF-1:0] fwd_wdata;
  logic [AW-1:0]   aluop;
  logic [SW-1:0]   alusel;
  logic [DW-1:0]   reg1, reg2, pc_out;
  logic [4:0]      wd;
  logic            wreg, inv;

  id_fwd_stage #(.DATA_W(DW), .NFWD(NF), .AOP_W(AW), .ASEL_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc), .inst_i(inst), .flush_i(flush),
    .reg1_read_o(r1_en), .reg2_read_o(r2_en),
    .reg1_addr_o(r1_addr), .reg2_addr_o(r2_addr),
    .reg1_data_i(rd1), .reg2_data_i(rd2),
    .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata), .fwd_rdy_i(fwd_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1), .reg2_o(reg2),
    .wd_o(wd), .wreg_o(wreg), .pc_o(pc_out), .inst_invalid_o(inv)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ok;
    logic [7:0]  aop;
    logic [2:0]  asel;
    logic        r1;
    logic        r2;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [4:0]  wd;
    logic        we;
    logic [1:0]  cond;   // 1 = write if rt != 0, 2 = write if rt == 0
  } dec_t;

  function automatic dec_t mk(input logic [7:0] aop, input logic [2:0] asel, input logic r1,
                              input logic r2, input logic we, input logic [4:0] dst,
                              input logic [1:0] cond);
    dec_t d;
    d = '0;
    d.ok = 1'b1; d.aop = aop; d.asel = asel; d.r1 = r1; d.r2 = r2;
    d.we = we; d.wd = we ? dst : 5'd0; d.cond = cond;
    return d;
  endfunction

  // Instruction-level meaning of each supported mnemonic
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6]; fn = w[5:0];
    d = '0;
    if (op == 6'h00 && sa == 5'd0) begin
      case (fn)
        6'h24: d = mk(A_AND,  S_LOGIC, 1, 1, 1, rd, 0);
        6'h25: d = mk(A_OR,   S_LOGIC, 1, 1, 1, rd, 0);
        6'h26: d = mk(A_XOR,  S_LOGIC, 1, 1, 1, rd, 0);
        6'h27: d = mk(A_NOR,  S_LOGIC, 1, 1, 1, rd, 0);
        6'h04: d = mk(A_SLL,  S_SHIFT, 1, 1, 1, rd, 0);
        6'h06: d = mk(A_SRL,  S_SHIFT, 1, 1, 1, rd, 0);
        6'h07: d = mk(A_SRA,  S_SHIFT, 1, 1, 1, rd, 0);
        6'h10: d = mk(A_MFHI, S_MOVE,  0, 0, 1, rd, 0);
        6'h12: d = mk(A_MFLO, S_MOVE,  0, 0, 1, rd, 0);
        6'h11: d = mk(A_MTHI, S_NOP,   1, 0, 0, rd, 0);
        6'h13: d = mk(A_MTLO, S_NOP,   1, 0, 0, rd, 0);
        6'h0B: d = mk(A_MOVN, S_MOVE,  1, 1, 1, rd, 1);
        6'h0A: d = mk(A_MOVZ, S_MOVE,  1, 1, 1, rd, 2);
        6'h0F: d = mk(A_NOP,  S_NOP,   0, 0, 0, rd, 0);
        default: ;
      endcase
    end
    if (op == 6'h00 && rs == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      d = mk(fn == 6'h00 ? A_SLL : (fn == 6'h02 ? A_SRL : A_SRA), S_SHIFT, 0, 1, 1, rd, 0);
      d.imm1 = {27'd0, sa};
    end
    case (op)
      6'h0D: begin d = mk(A_OR,  S_LOGIC, 1, 0, 1, rt, 0); d.imm2 = {16'd0, w[15:0]}; end
      6'h0C: begin d = mk(A_AND, S_LOGIC, 1, 0, 1, rt, 0); d.imm2 = {16'd0, w[15:0]}; end
      6'h0E: begin d = mk(A_XOR, S_LOGIC, 1, 0, 1, rt, 0); d.imm2 = {16'd0, w[15:0]}; end
      6'h0F: begin d = mk(A_OR,  S_LOGIC, 0, 0, 1, rt, 0); d.imm2 = {w[15:0], 16'd0}; end
      6'h33: d = mk(A_NOP, S_NOP, 0, 0, 0, rt, 0);
      default: ;
    endcase
    return d;
  endfunction

  // {stall, value}: first matching source from the youngest wins
  function automatic logic [32:0] resolve(input logic en, input logic [4:0] a,
                                          input logic [31:0] imm, input logic [31:0] rf);
    if (!en) return {1'b0, imm};
    if (a == 5'd0) return 33'd0;
    for (int k = 0; k < int'(NF); k++)
      if (fwd_wreg[k] && fwd_wd[5*k +: 5] == a) return {!fwd_rdy[k], fwd_wdata[32*k +: 32]};
    return {1'b0, rf};
  endfunction

  logic        e_valid = 1'b0, e_chk = 1'b0, e_we = 1'b0, e_inv = 1'b0;
  logic [7:0]  e_aop = '0;
  logic [2:0]  e_asel = '0;
  logic [31:0] e_r1 = '0, e_r2 = '0, e_pc = '0;
  logic [4:0]  e_wd = '0;
  logic        last_ready;

  // Inputs are set at negedge; check combinational outputs, then the edge result
  task automatic cycle();
    dec_t d;
    logic [32:0] a, b;
    logic rdy, we;
    #1;
    d = decode(inst);
    a = resolve(d.r1, inst[25:21], d.imm1, rd1);
    b = resolve(d.r2, inst[20:16], d.imm2, rd2);
    rdy = rst && !flush && !(a[32] || b[32]) && (!e_valid || out_ready);
    last_ready = in_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    check("rd_en", {62'd0, r1_en, r2_en}, {62'd0, d.r1, d.r2});
    check("rd_addr", {54'd0, r1_addr, r2_addr}, {54'd0, inst[25:16]});
    we = d.we && d.wd != 5'd0 && (d.cond != 2'd1 || b[31:0] != 0) && (d.cond != 2'd2 || b[31:0] == 0);
    @(posedge clk);
    if (!rst) begin
      e_valid = 0; e_chk = 1; e_aop = A_NOP; e_asel = S_NOP; e_r1 = 0; e_r2 = 0;
      e_wd = 0; e_we = 0; e_pc = 0; e_inv = 0;
    end else if (flush) begin
      e_valid = 0; e_chk = 0;
    end else if (in_valid && rdy) begin
      e_valid = 1; e_chk = 1; e_aop = d.aop; e_asel = d.asel; e_r1 = a[31:0]; e_r2 = b[31:0];
      e_wd = d.wd; e_we = we; e_pc = pc; e_inv = !d.ok;
    end else if (out_ready) begin
      e_valid = 0; e_chk = 0;
    end
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
    if (e_chk) begin
      check("aluop", {56'd0, aluop}, {56'd0, e_aop});
      check("alusel", {61'd0, alusel}, {61'd0, e_asel});
      check("reg1", {32'd0, reg1}, {32'd0, e_r1});
      check("reg2", {32'd0, reg2}, {32'd0, e_r2});
      check("wd", {59'd0, wd}, {59'd0, e_wd});
      check("wreg", {63'd0, wreg}, {63'd0, e_we});
      check("pc", {32'd0, pc_out}, {32'd0, e_pc});
      check("invalid", {63'd0, inv}, {63'd0, e_inv});
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; fwd_rdy = '1; flush = 0; rd1 = 0; rd2 = 0;
  endtask

  logic [5:0] sp_fn [14];
  logic [5:0] sh_fn [3];
  logic [5:0] i_op  [5];

  function automatic logic [31:0] rnd_inst();
    logic [4:0] rs, rt, rd, sa;
    int pick;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    sa = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    pick = $urandom_range(0, 24);
    if (pick < 14) return {6'd0, rs, rt, rd, sa, sp_fn[pick]};
    if (pick < 17) return {6'd0, ($urandom_range(0, 7) == 0) ? rs : 5'd0, rt, rd,
                           5'($urandom_range(0, 31)), sh_fn[pick-14]};
    if (pick < 22) return {i_op[pick-17], rs, rt, 16'($urandom)};
    if (pick == 22) return 32'd0;
    return 32'($urandom);
  endfunction

  logic [31:0] hold_r2;

  initial begin
    sp_fn = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h11,
              6'h13, 6'h0B, 6'h0A, 6'h0F};
    sh_fn = '{6'h00, 6'h02, 6'h03};
    i_op  = '{6'h0D, 6'h0C, 6'h0E, 6'h0F, 6'h33};
    quiet();
    rst = 0; in_valid = 0; out_ready = 1; inst = 0; pc = 0;
    @(negedge clk);
    cycle(); cycle();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_aluop", {56'd0, aluop}, 64'd0);

    // ori $1,$0,0x1100
    rst = 1; in_valid = 1; inst = 32'h34011100; pc = 32'h100;
    cycle();
    check("ori_valid", {63'd0, out_valid}, 64'd1);
    check("ori_wd", {59'd0, wd}, 64'd1);
    check("ori_wreg", {63'd0, wreg}, 64'd1);
    check("ori_reg1", {32'd0, reg1}, 64'd0);
    check("ori_reg2", {32'd0, reg2}, 64'h1100);
    check("ori_aluop", {56'd0, aluop}, 64'h25);

    // or $3,$1,$2 with two sources forwarding $1
    inst = 32'h00221825; pc = 32'h104; rd1 = 32'hDEAD; rd2 = 32'h5555;
    fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h1, 32'hAAAA0000}; fwd_rdy = 2'b11;
    cycle();
    check("fwd_young", {32'd0, reg1}, 64'hAAAA0000);
    check("fwd_rf", {32'd0, reg2}, 64'h5555);

    // and $4,$5,$6 stalled on a pending $5
    quiet();
    inst = 32'h00A62024; pc = 32'h108; rd2 = 32'h0F0F;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd5}; fwd_rdy = 2'b00; fwd_wdata = {32'h0, 32'hBAD0BAD0};
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", {63'd0, last_ready}, 64'd0);
    end
    fwd_rdy = 2'b01; fwd_wdata = {32'h0, 32'h12345678};
    cycle();
    check("stall_cap", {32'd0, reg1}, 64'h12345678);

    // movz $7,$8,$9
    quiet();
    inst = 32'h0109380A; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd9}; fwd_wdata = {32'h0, 32'h0};
    cycle();
    check("movz_zero", {63'd0, wreg}, 64'd1);
    fwd_wdata = {32'h0, 32'h5};
    cycle();
    check("movz_nz", {63'd0, wreg}, 64'd0);
    quiet(); inst = 32'h0;
    cycle();
    check("nop_wreg", {63'd0, wreg}, 64'd0);

    // xori $10,$0,0xBEEF held under backpressure, then flushed
    inst = 32'h380ABEEF;
    cycle();
    hold_r2 = reg2;
    check("xori_reg2", {32'd0, reg2}, 64'hBEEF);
    out_ready = 0; inst = 32'h34011100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("hold_ready", {63'd0, last_ready}, 64'd0);
      check("hold_reg2", {32'd0, reg2}, {32'd0, hold_r2});
    end
    flush = 1;
    cycle();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 0; in_valid = 0;
    cycle();
    check("flush_nocap", {63'd0, out_valid}, 64'd0);

    // reset while holding, then an undecoded opcode
    out_ready = 1; in_valid = 1; inst = 32'h34011100; pc = 32'h200;
    cycle();
    rst = 0;
    cycle();
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_reg2", {32'd0, reg2}, 64'd0);
    check("rst_mid_pc", {32'd0, pc_out}, 64'd0);
    rst = 1; inst = 32'hFC000000;
    cycle();
    check("undef_inv", {63'd0, inv}, 64'd1);
    check("undef_wreg", {63'd0, wreg}, 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inst      = rnd_inst();
      pc        = $urandom;
      rd1       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rd2       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      fwd_wreg  = NF'($urandom);
      for (int k = 0; k < int'(NF); k++) begin
        fwd_wd[5*k +: 5]     = 5'($urandom_range(0, 7));
        fwd_wdata[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        fwd_rdy[k]           = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
